// File: rtl/brus16_pkg.sv
// Shared brus16 types and memory-map constants used by the frame scheduler,
// the GPU rectangle buffer and the firmware linker map.
package brus16_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COPY  = 2'd1,
        START = 2'd2,
        RUN   = 2'd3
    } sched_state_t;

    localparam int          RECT_COUNT     = 64;
    localparam int          RECT_WORD_SIZE = 5;
    localparam logic [12:0] DEF_RECT_BASE  = 13'h1C00;
    localparam int          DEF_RECT_WORDS = RECT_COUNT * RECT_WORD_SIZE;

endpackage

// File: rtl/frame_scheduler_rect_dma.sv
// Rectangle-table copier: walks RECT_WORDS data-RAM words and replays them
// into the GPU buffer one cycle after each registered read returns.
module rect_dma #(
    parameter int                    DATA_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] RECT_BASE  = '0,
    parameter int                    RECT_WORDS = 320,
    parameter int                    GPU_AW     = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_run,
    input  logic [15:0]           i_rd_data,
    output logic [DATA_WIDTH-1:0] o_rd_addr,
    output logic                  o_gpu_we,
    output logic [GPU_AW-1:0]     o_gpu_addr,
    output logic [15:0]           o_gpu_data,
    output logic                  o_last_wr,
    output logic                  o_done
);

    localparam int             IW   = GPU_AW + 1;
    localparam logic [IW-1:0] LAST = IW'(RECT_WORDS - 1);

    logic [IW-1:0]     r_idx;
    logic              r_pend;
    logic [GPU_AW-1:0] r_pend_addr;
    logic              r_pend_last;
    logic              r_gpu_we;
    logic [GPU_AW-1:0] r_gpu_addr;
    logic [15:0]       r_gpu_data;
    logic              r_done;
    logic              w_issue;

    // Index parks at RECT_WORDS once every read has gone out.
    assign w_issue   = i_run & (r_idx <= LAST);
    assign o_rd_addr = RECT_BASE + DATA_WIDTH'(r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_pend_last <= 1'b0;
            r_gpu_we    <= 1'b0;
            r_gpu_addr  <= '0;
            r_gpu_data  <= '0;
            r_done      <= 1'b0;
        end else begin
            if (!i_run) begin
                r_idx <= '0;
            end else if (w_issue) begin
                r_idx <= r_idx + 1'b1;
            end
            r_pend      <= w_issue;
            r_pend_addr <= r_idx[GPU_AW-1:0];
            r_pend_last <= w_issue & (r_idx == LAST);
            r_gpu_we    <= r_pend;
            if (r_pend) begin
                r_gpu_addr <= r_pend_addr;
                r_gpu_data <= i_rd_data;
            end
            r_done <= r_pend_last;
        end
    end

    assign o_gpu_we   = r_gpu_we;
    assign o_gpu_addr = r_gpu_addr;
    assign o_gpu_data = r_gpu_data;
    assign o_last_wr  = r_pend_last;
    assign o_done     = r_done;

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame brus16 sequencer: copies the rectangle table to the GPU on vsync,
// then releases the CPU until it reports the frame done.
module frame_scheduler #(
    parameter int                    DATA_WIDTH = 13,
    parameter logic [DATA_WIDTH-1:0] RECT_BASE  =
        DATA_WIDTH'(brus16_pkg::DEF_RECT_BASE),
    parameter int                    RECT_WORDS = brus16_pkg::DEF_RECT_WORDS,
    parameter int                    GPU_AW     = 9
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  vsync,
    input  logic                  cpu_done,
    output logic                  cpu_reset,
    input  logic [DATA_WIDTH-1:0] cpu_mem_rd_addr,
    input  logic                  cpu_mem_we,
    output logic [DATA_WIDTH-1:0] mem_rd_addr,
    input  logic [15:0]           mem_rd_data,
    output logic                  mem_we,
    output logic                  gpu_we,
    output logic [GPU_AW-1:0]     gpu_addr,
    output logic [15:0]           gpu_data,
    output logic                  frame_overrun,
    output logic [15:0]           frame_count
);

    import brus16_pkg::*;

    sched_state_t          r_state;
    sched_state_t          w_next;
    logic                  r_cpu_reset;
    logic                  r_overrun;
    logic [15:0]           r_frame_count;
    logic                  w_copy;
    logic                  w_run;
    logic                  w_ovr_set;
    logic                  w_dma_last;
    logic                  w_dma_done;
    logic [DATA_WIDTH-1:0] w_dma_addr;

    assign w_copy    = (r_state == COPY);
    assign w_run     = (r_state == RUN);
    assign w_ovr_set = w_run & vsync & ~cpu_done;

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (vsync) w_next = COPY;
            COPY:    if (w_dma_done) w_next = START;
            START:   w_next = RUN;
            RUN:     if (cpu_done) w_next = vsync ? COPY : IDLE;
            default: w_next = IDLE;
        endcase
    end

    // cpu_reset is registered off the next state so it is glitch-free.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= IDLE;
            r_cpu_reset   <= 1'b1;
            r_overrun     <= 1'b0;
            r_frame_count <= '0;
        end else begin
            r_state     <= w_next;
            r_cpu_reset <= (w_next != RUN);
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end
            if (w_dma_last) begin
                r_frame_count <= r_frame_count + 16'd1;
            end
        end
    end

    rect_dma #(
        .DATA_WIDTH (DATA_WIDTH),
        .RECT_BASE  (RECT_BASE),
        .RECT_WORDS (RECT_WORDS),
        .GPU_AW     (GPU_AW)
    ) u_dma (
        .clk        (clk),
        .rst_n      (reset),
        .i_run      (w_copy),
        .i_rd_data  (mem_rd_data),
        .o_rd_addr  (w_dma_addr),
        .o_gpu_we   (gpu_we),
        .o_gpu_addr (gpu_addr),
        .o_gpu_data (gpu_data),
        .o_last_wr  (w_dma_last),
        .o_done     (w_dma_done)
    );

    // CPU writes are gated so a held CPU cannot corrupt the table.
    assign mem_rd_addr   = w_copy ? w_dma_addr : cpu_mem_rd_addr;
    assign mem_we        = cpu_mem_we & w_run;
    assign cpu_reset     = r_cpu_reset;
    assign frame_overrun = r_overrun;
    assign frame_count   = r_frame_count;

endmodule
